// File: rtl/scedma_seg_copy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scedma_seg_copy                                                            |
// | Segment-to-segment copy channel: wrapping read/write pointers, credit-     |
// | limited in-order read-data buffer.                                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module scedma_seg_copy #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int TRANSCNTW = 30,
  parameter int BUFDEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [AW-1:0]        rp_segaddr,
  input  logic [AW-1:0]        rp_segsize,
  input  logic [AW-1:0]        rp_ptr_start,
  input  logic [AW-1:0]        wp_segaddr,
  input  logic [AW-1:0]        wp_segsize,
  input  logic [AW-1:0]        wp_ptr_start,
  input  logic [TRANSCNTW-1:0] transsize,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [AW-1:0]        rd_segaddr,
  output logic [AW-1:0]        rd_segptr,
  output logic                 rd_req,
  input  logic                 rd_ready,
  input  logic [DW-1:0]        rd_rdat,
  input  logic                 rd_rdatvld,
  output logic [AW-1:0]        wr_segaddr,
  output logic [AW-1:0]        wr_segptr,
  output logic                 wr_req,
  output logic [DW-1:0]        wr_wdat,
  input  logic                 wr_ready
);

  localparam int PW = $clog2(BUFDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] c_depth = (CW+1)'(BUFDEPTH);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        rseg_q, rseg_d, rsize_q, rsize_d, rptr_q, rptr_d;
  logic [AW-1:0]        wseg_q, wseg_d, wsize_q, wsize_d, wptr_q, wptr_d;
  logic [TRANSCNTW-1:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic [CW-1:0]        outst_q, outst_d, occ_q, occ_d;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic                 err_q, err_d;
  logic [DW-1:0]        mem_q [BUFDEPTH];

  logic          w_accept, w_cfg_bad, w_zero_len;
  logic          w_rd_acc, w_wr_acc, w_push;
  logic [CW:0]   w_used;
  logic [AW-1:0] w_rptr_nxt, w_wptr_nxt;

  assign w_accept   = (state_q == c_idle) && start;
  assign w_zero_len = (transsize == '0);
  assign w_cfg_bad  = (rp_segsize == '0) || (wp_segsize == '0) ||
                      (rp_ptr_start >= rp_segsize) || (wp_ptr_start >= wp_segsize);

  assign w_rd_acc = rd_req && rd_ready;
  assign w_wr_acc = wr_req && wr_ready;
  // A return with nothing outstanding is a stale response from before a reset.
  assign w_push   = rd_rdatvld && (outst_q != '0);
  assign w_used   = {1'b0, outst_q} + {1'b0, occ_q};

  assign w_rptr_nxt = (rptr_q == rsize_q - AW'(1)) ? '0 : rptr_q + AW'(1);
  assign w_wptr_nxt = (wptr_q == wsize_q - AW'(1)) ? '0 : wptr_q + AW'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= c_idle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:  if (start) state_d = (w_cfg_bad || w_zero_len) ? c_done : c_run;
      c_run:   if (w_wr_acc && (wcnt_q == TRANSCNTW'(1))) state_d = c_done;
      c_done:  state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    rd_req = 1'b0;
    wr_req = 1'b0;
    case (state_q)
      c_run: begin
        busy   = 1'b1;
        rd_req = (rcnt_q != '0) && (w_used < c_depth);
        wr_req = (occ_q != '0);
      end
      c_done:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rseg_d  = rseg_q;
    rsize_d = rsize_q;
    rptr_d  = rptr_q;
    wseg_d  = wseg_q;
    wsize_d = wsize_q;
    wptr_d  = wptr_q;
    rcnt_d  = rcnt_q;
    wcnt_d  = wcnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    err_d   = err_q;
    outst_d = outst_q + CW'(w_rd_acc) - CW'(w_push);
    occ_d   = occ_q + CW'(w_push) - CW'(w_wr_acc);
    if (w_accept) begin
      rseg_d  = rp_segaddr;
      rsize_d = rp_segsize;
      rptr_d  = rp_ptr_start;
      wseg_d  = wp_segaddr;
      wsize_d = wp_segsize;
      wptr_d  = wp_ptr_start;
      rcnt_d  = transsize;
      wcnt_d  = transsize;
      err_d   = w_cfg_bad;
    end else begin
      if (w_rd_acc) begin
        rcnt_d = rcnt_q - TRANSCNTW'(1);
        rptr_d = w_rptr_nxt;
      end
      if (w_wr_acc) begin
        wcnt_d = wcnt_q - TRANSCNTW'(1);
        wptr_d = w_wptr_nxt;
        head_d = head_q + PW'(1);
      end
      if (w_push) tail_d = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rseg_q  <= '0;
      rsize_q <= '0;
      rptr_q  <= '0;
      wseg_q  <= '0;
      wsize_q <= '0;
      wptr_q  <= '0;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
      outst_q <= '0;
      occ_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      rseg_q  <= rseg_d;
      rsize_q <= rsize_d;
      rptr_q  <= rptr_d;
      wseg_q  <= wseg_d;
      wsize_q <= wsize_d;
      wptr_q  <= wptr_d;
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
      outst_q <= outst_d;
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[tail_q] <= rd_rdat;
  end

  assign err        = err_q;
  assign rd_segaddr = rseg_q;
  assign rd_segptr  = rptr_q;
  assign wr_segaddr = wseg_q;
  assign wr_segptr  = wptr_q;
  assign wr_wdat    = wr_req ? mem_q[head_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_scedma_seg_copy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_scedma_seg_copy                                                         |
// | Directed bench for the segment copy channel with a latency memory model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_scedma_seg_copy;

  localparam int MAXLOG = 2048;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [11:0] rp_segaddr = '0, rp_segsize = '0, rp_ptr_start = '0;
  logic [11:0] wp_segaddr = '0, wp_segsize = '0, wp_ptr_start = '0;
  logic [29:0] transsize = '0;
  logic        busy, done, err, rd_req, wr_req;
  logic [11:0] rd_segaddr, rd_segptr, wr_segaddr, wr_segptr;
  logic [31:0] wr_wdat;
  logic        rd_ready = 1'b0, rd_rdatvld = 1'b0, wr_ready = 1'b0;
  logic [31:0] rd_rdat = '0;

  scedma_seg_copy dut (
    .clk(clk), .resetn(resetn), .start(start),
    .rp_segaddr(rp_segaddr), .rp_segsize(rp_segsize), .rp_ptr_start(rp_ptr_start),
    .wp_segaddr(wp_segaddr), .wp_segsize(wp_segsize), .wp_ptr_start(wp_ptr_start),
    .transsize(transsize), .busy(busy), .done(done), .err(err),
    .rd_segaddr(rd_segaddr), .rd_segptr(rd_segptr), .rd_req(rd_req),
    .rd_ready(rd_ready), .rd_rdat(rd_rdat), .rd_rdatvld(rd_rdatvld),
    .wr_segaddr(wr_segaddr), .wr_segptr(wr_segptr), .wr_req(wr_req),
    .wr_wdat(wr_wdat), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dmem(input logic [11:0] seg, input logic [11:0] ptr);
    return {8'hD5, seg, ptr};
  endfunction

  // Stimulus knobs, written by the main process only
  int lat = 1;
  int wr_hold = -1;
  bit rnd_mode = 1'b0;

  // Monitor / memory model state, written by the monitor only
  int cyc = 0, t0 = 0, rc = 0;
  int busy_first = -1, rdreq_first = -1, done_cyc = -1, done_cnt = 0;
  bit busy_seen = 1'b0, rdreq_seen = 1'b0, err_at_done = 1'b0, busy_at_done = 1'b0;
  int rd_n = 0, wr_n = 0, max_inflight = 0, rd_at_hold = -1;
  logic [11:0] rd_ptr_log [MAXLOG];
  logic [11:0] wr_ptr_log [MAXLOG];
  logic [11:0] wr_adr_log [MAXLOG];
  logic [31:0] wr_dat_log [MAXLOG];
  int          due_q [$];
  logic [31:0] dat_q [$];

  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      due_q.delete();
      dat_q.delete();
    end
    if (start && resetn && !busy && !done) begin
      t0 = cyc;
      busy_first = -1; rdreq_first = -1; done_cyc = -1; done_cnt = 0;
      busy_seen = 0; rdreq_seen = 0; err_at_done = 0; busy_at_done = 0;
      rd_n = 0; wr_n = 0; max_inflight = 0; rd_at_hold = -1;
    end
    rc = cyc - t0;
    if (busy) busy_seen = 1;
    if (busy && busy_first < 0) busy_first = rc;
    if (rd_req) rdreq_seen = 1;
    if (rd_req && rdreq_first < 0) rdreq_first = rc;
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) begin
        done_cyc = rc;
        err_at_done = err;
        busy_at_done = busy;
      end
    end
    rd_rdatvld = 1'b0;
    rd_rdat = '0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      rd_rdatvld = 1'b1;
      rd_rdat = dat_q.pop_front();
      void'(due_q.pop_front());
    end
    rd_ready = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    wr_ready = (rc > wr_hold) && (rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (rc == wr_hold) rd_at_hold = rd_n;
    if (rd_req && rd_ready) begin
      if (rd_n < MAXLOG) rd_ptr_log[rd_n] = rd_segptr;
      due_q.push_back(cyc + lat);
      dat_q.push_back(dmem(rd_segaddr, rd_segptr));
      rd_n++;
    end
    if (wr_req && wr_ready) begin
      if (wr_n < MAXLOG) begin
        wr_ptr_log[wr_n] = wr_segptr;
        wr_adr_log[wr_n] = wr_segaddr;
        wr_dat_log[wr_n] = wr_wdat;
      end
      wr_n++;
    end
    if (rd_n - wr_n > max_inflight) max_inflight = rd_n - wr_n;
  end

  task automatic set_cmd(input logic [11:0] rs, rz, rp, ws, wz, wp, input logic [29:0] n,
                         input int l, input int wh, input bit rnd);
    rp_segaddr = rs; rp_segsize = rz; rp_ptr_start = rp;
    wp_segaddr = ws; wp_segsize = wz; wp_ptr_start = wp;
    transsize = n; lat = l; wr_hold = wh; rnd_mode = rnd;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [11:0] rs, rz, rp, ws, wz, wp,
                         input logic [29:0] n, input int l, input int wh, input bit rnd,
                         input int budget);
    int w = 0;
    set_cmd(rs, rz, rp, ws, wz, wp, n, l, wh, rnd);
    while (done_cyc < 0 && w < budget) begin
      @(posedge clk);
      w++;
    end
    check({tag, "_timeout"}, 64'(done_cyc < 0), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic verify(input string tag, input int n, input logic [11:0] rs, rz, rp, ws, wz, wp);
    int rerr = 0, perr = 0, derr = 0, aerr = 0;
    check({tag, "_rd_count"}, 64'(rd_n), 64'(n));
    check({tag, "_wr_count"}, 64'(wr_n), 64'(n));
    for (int i = 0; i < n && i < MAXLOG; i++) begin
      logic [11:0] re, we;
      re = 12'((int'(rp) + i) % int'(rz));
      we = 12'((int'(wp) + i) % int'(wz));
      if (rd_ptr_log[i] !== re) rerr++;
      if (wr_ptr_log[i] !== we) perr++;
      if (wr_adr_log[i] !== ws) aerr++;
      if (wr_dat_log[i] !== dmem(rs, re)) derr++;
    end
    check({tag, "_rd_ptr_errs"}, 64'(rerr), 64'd0);
    check({tag, "_wr_ptr_errs"}, 64'(perr), 64'd0);
    check({tag, "_wr_addr_errs"}, 64'(aerr), 64'd0);
    check({tag, "_data_errs"}, 64'(derr), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_rd_req"}, 64'(rd_req), 64'd0);
    check({tag, "_wr_req"}, 64'(wr_req), 64'd0);
    check({tag, "_rd_segptr"}, 64'(rd_segptr), 64'd0);
    check({tag, "_wr_segptr"}, 64'(wr_segptr), 64'd0);
    check({tag, "_rd_segaddr"}, 64'(rd_segaddr), 64'd0);
    check({tag, "_wr_segaddr"}, 64'(wr_segaddr), 64'd0);
    check({tag, "_wr_wdat"}, 64'(wr_wdat), 64'd0);
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_cmd("basic", 12'h040, 12'd64, 12'd0, 12'h100, 12'd64, 12'd0, 30'd8, 1, -1, 1'b0, 100);
    check("basic_busy_cycle", 64'(busy_first), 64'd1);
    check("basic_rdreq_cycle", 64'(rdreq_first), 64'd1);
    check("basic_done_cycle", 64'(done_cyc), 64'd11);
    check("basic_done_pulses", 64'(done_cnt), 64'd1);
    check("basic_busy_at_done", 64'(busy_at_done), 64'd0);
    check("basic_err", 64'(err_at_done), 64'd0);
    verify("basic", 8, 12'h040, 12'd64, 12'd0, 12'h100, 12'd64, 12'd0);

    run_cmd("wrap", 12'h200, 12'd4, 12'd2, 12'h300, 12'd3, 12'd1, 30'd6, 1, -1, 1'b0, 100);
    check("wrap_err", 64'(err_at_done), 64'd0);
    verify("wrap", 6, 12'h200, 12'd4, 12'd2, 12'h300, 12'd3, 12'd1);

    run_cmd("bp", 12'h010, 12'd16, 12'd14, 12'h020, 12'd8, 12'd5, 30'd10, 3, 20, 1'b0, 300);
    check("bp_reads_during_stall", 64'(rd_at_hold), 64'd4);
    check("bp_max_inflight", 64'(max_inflight), 64'd4);
    verify("bp", 10, 12'h010, 12'd16, 12'd14, 12'h020, 12'd8, 12'd5);

    run_cmd("rnd", 12'h7A0, 12'd37, 12'd5, 12'h0B0, 12'd50, 12'd49, 30'd1000, 2, -1, 1'b1, 20000);
    check("rnd_credit_ok", 64'(max_inflight <= 4), 64'd1);
    verify("rnd", 1000, 12'h7A0, 12'd37, 12'd5, 12'h0B0, 12'd50, 12'd49);
    rnd_mode = 1'b0;

    run_cmd("zero", 12'h040, 12'd64, 12'd0, 12'h100, 12'd64, 12'd0, 30'd0, 1, -1, 1'b0, 20);
    check("zero_done_cycle", 64'(done_cyc), 64'd1);
    check("zero_err", 64'(err_at_done), 64'd0);
    check("zero_rdreq_seen", 64'(rdreq_seen), 64'd0);
    check("zero_busy_seen", 64'(busy_seen), 64'd0);

    run_cmd("badptr", 12'h040, 12'd64, 12'd64, 12'h100, 12'd64, 12'd0, 30'd4, 1, -1, 1'b0, 20);
    check("badptr_done_cycle", 64'(done_cyc), 64'd1);
    check("badptr_err", 64'(err_at_done), 64'd1);
    check("badptr_busy_seen", 64'(busy_seen), 64'd0);
    check("badptr_rdreq_seen", 64'(rdreq_seen), 64'd0);
    check("badptr_err_held", 64'(err), 64'd1);

    set_cmd(12'h050, 12'd32, 12'd3, 12'h150, 12'd32, 12'd7, 30'd16, 1, -1, 1'b0);
    w = 0;
    while (wr_n < 5 && w < 200) begin
      @(posedge clk);
      w++;
    end
    check("midrst_reach_word5", 64'(wr_n >= 5), 64'd1);
    #3 resetn = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_cmd("after", 12'h040, 12'd64, 12'd10, 12'h100, 12'd64, 12'd20, 30'd8, 1, -1, 1'b0, 100);
    check("after_done_cycle", 64'(done_cyc), 64'd11);
    check("after_err", 64'(err_at_done), 64'd0);
    verify("after", 8, 12'h040, 12'd64, 12'd10, 12'h100, 12'd64, 12'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/scedma_seg_copy.md
# scedma_seg_copy

Segment-to-segment copy channel for the SCE DMA. It takes one channel command: source and destination segments, start pointers and a word count. It then issues read requests on a source port and write requests on a destination port, towards the SCE memory controller arbiter. Data passes through a small in-order buffer. Pointers wrap within each segment, so FIFO-type segments are handled transparently.

## Interface
- AW, 12, segment address/pointer width (words)
- DW, 32, data width
- TRANSCNTW, 30, transfer-count width
- BUFDEPTH, 4, read-data buffer depth (power of two, ≥2)

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  command strobe; sampled only in IDLE
- rp_segaddr  in  AW  source segment base
- rp_segsize  in  AW  source segment size (words)
- rp_ptr_start  in  AW  source start pointer
- wp_segaddr  in  AW  destination segment base
- wp_segsize  in  AW  destination segment size
- wp_ptr_start  in  AW  destination start pointer
- transsize  in  TRANSCNTW  words to copy
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  config error; held until next accepted start
- rd_segaddr  out  AW  latched rp_segaddr
- rd_segptr  out  AW  current source pointer
- rd_req  out  1  read request
- rd_ready  in  1  read request accepted when rd_req && rd_ready
- rd_rdat  in  DW  read data
- rd_rdatvld  in  1  read data valid; returns in request order, ≥1 cycle after acceptance
- wr_segaddr  out  AW  latched wp_segaddr
- wr_segptr  out  AW  current destination pointer
- wr_req  out  1  write request
- wr_wdat  out  DW  write data (buffer head)
- wr_ready  in  1  write accepted when wr_req && wr_ready

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start when config is valid. All inputs are latched. Pointers load from the *_ptr_start inputs. Read and write counters load transsize.
- IDLE → DONE on start if any of the following hold:
  - transsize==0: no accesses, err=0.
  - rp_segsize==0 or wp_segsize==0: err=1.
  - rp_ptr_start≥rp_segsize or wp_ptr_start≥wp_segsize: err=1.
- RUN → DONE in the cycle the last write is accepted (write counter reaches 0).
- DONE → IDLE unconditionally after one cycle. done=1 only in DONE.
- Read issue: rd_req=1 in RUN when all of the following hold:
  - the read counter is nonzero;
  - outstanding + occupancy < BUFDEPTH. "Outstanding" counts reads accepted whose data has not yet returned.
- Read bookkeeping:
  - On rd_req&&rd_ready, decrement the read counter and advance the source pointer.
  - On rd_rdatvld, push rd_rdat into the buffer and decrement outstanding.
  - A push is guaranteed never to overflow, by the credit rule above.
  - rd_rdatvld with zero outstanding is ignored.
- Write issue: wr_req=1 in RUN when the buffer is non-empty. wr_wdat = buffer head.
- Write bookkeeping: on acceptance, pop the buffer, decrement the write counter and advance the destination pointer.
- Pointer wrap: ptr_next = (ptr == segsize−1) ? 0 : ptr+1. This is AW-bit arithmetic and never exceeds segsize−1.
- Simultaneous push and pop in one cycle: occupancy is unchanged and both take effect.
- Simultaneous accept and return on the read side: outstanding is unchanged.
- start while busy is ignored.
- Reset (including mid-transfer): state=IDLE, buffer emptied, counters cleared. The in-flight memc response is discarded. The arbiter must be reset with the block.
- Reset values: busy=0, done=0, err=0, rd_req=0, wr_req=0, rd_segptr=0, wr_segptr=0, rd_segaddr=0, wr_segaddr=0, wr_wdat=0.

## Timing
- start at cycle 0 → busy=1 and rd_req=1 from cycle 1 (registered).
- The buffer is registered. Data returned at cycle n gives wr_req=1 at cycle n+1.
- Minimum per-word latency is rd accept at n, rdatvld at n+1, wr_req at n+2, done at (last write accept)+1.
- With rd_ready=wr_ready=1 and 1-cycle read latency, throughput is 1 word/cycle once the pipeline fills.
- busy falls in the same cycle done rises. done holds for exactly one cycle.
- Error or zero-length command: done at cycle 1, busy=0 throughout. err is valid at cycle 1 and holds.
- rd_segptr and wr_segptr always show the pointer of the next request. They hold their value while the request is stalled.

## Test plan
- Basic copy: rp_segaddr=0x40, rp_ptr_start=0, size 64; wp_segaddr=0x100, wp_ptr_start=0, size 64; transsize=8; readies=1; 1-cycle read latency → rd ptrs 0..7, wr ptrs 0..7, data matches, done at cycle 11, err=0.
- Wrap: rp_segsize=4, rp_ptr_start=2, wp_segsize=3, wp_ptr_start=1, transsize=6 → rd ptrs 2,3,0,1,2,3; wr ptrs 1,2,0,1,2,0.
- Backpressure: wr_ready=0 for 20 cycles, read latency 3 → at most BUFDEPTH=4 reads accepted; no overflow; after release, all 10 words are written in order.
- Random rd_ready/wr_ready over 1000 words → sequence integrity. outstanding+occupancy≤4 every cycle.
- Config: transsize=0 → done at cycle 1, err=0, no rd_req. rp_ptr_start=64 with rp_segsize=64 → done at cycle 1, err=1.
- resetn asserted mid-transfer at word 5 of 16 → all outputs at reset values immediately. A new start after reset completes correctly.
